// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM handshake states,
// arbiter FSM states and the default starvation threshold.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DGRANT = 2'd1,
      IGRANT = 2'd2
   } arb_state_t;

   localparam int STARVE_LIMIT_DEF = 8;
   localparam int STARVE_W         = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating icache wait counter; o_at_limit once the count has
// reached LIMIT (it may overshoot while the dcache holds the RAM).
module arb_starve_ctr
   import cpu_types_pkg::*;
#(
   parameter int LIMIT = STARVE_LIMIT_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_at_limit
);

   localparam logic [STARVE_W-1:0] LIM = STARVE_W'(LIMIT);

   logic [STARVE_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_at_limit = (r_cnt >= LIM);

endmodule

// File: rtl/memory_arbiter.sv
// icache/dcache to single RAM port arbiter with dcache block lock.
// MEMARB_STATS_EN adds per-requester ACCESS counters.
module memory_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        iwait,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dwait,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  ramstate_t   ramstate
`ifdef MEMARB_STATS_EN
   ,
   output logic [31:0] dacc_cnt,
   output logic [31:0] iacc_cnt
`endif
);

   arb_state_t r_state;
   arb_state_t w_next;
   logic       r_beat;
   logic       w_beat_nxt;
   logic       w_acc;
   logic       w_dreq;
   logic       w_iclr;
   logic       w_starved;

   assign w_acc  = (ramstate == ACCESS);
   assign w_dreq = dREN | dWEN;

   arb_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .i_clk      (CLK),
      .i_rst      (RST),
      .i_inc      (iREN && (r_state != IGRANT)),
      .i_clr      (w_iclr),
      .o_at_limit (w_starved)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_beat  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_beat  <= w_beat_nxt;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_beat_nxt = r_beat;
      w_iclr     = 1'b0;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;
      iwait      = 1'b1;
      dwait      = 1'b1;
      iload      = '0;
      dload      = '0;
      unique case (r_state)
         IDLE: begin
            if (w_starved && iREN) begin
               w_next = IGRANT;
            end else if (w_dreq) begin
               w_next     = DGRANT;
               w_beat_nxt = 1'b0;
            end else if (iREN) begin
               w_next = IGRANT;
            end
         end
         DGRANT: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            dload    = ramload;
            dwait    = ~w_acc;
            if (!w_dreq) begin
               w_next = IDLE;
            end else if (w_acc) begin
               // word 0 of a block keeps the grant for word 1
               if (!r_beat && !daddr[2]) begin
                  w_beat_nxt = 1'b1;
               end else begin
                  w_next = IDLE;
               end
            end
         end
         IGRANT: begin
            ramaddr = iaddr;
            ramREN  = 1'b1;
            iload   = ramload;
            iwait   = ~w_acc;
            if (w_acc) begin
               w_next = IDLE;
               w_iclr = 1'b1;
            end else if (!iREN) begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

`ifdef MEMARB_STATS_EN
   logic [31:0] r_dacc;
   logic [31:0] r_iacc;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_dacc <= '0;
         r_iacc <= '0;
      end else if (w_acc) begin
         if (r_state == DGRANT) r_dacc <= r_dacc + 32'd1;
         if (r_state == IGRANT) r_iacc <= r_iacc + 32'd1;
      end
   end

   assign dacc_cnt = r_dacc;
   assign iacc_cnt = r_iacc;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a per-cycle ownership model.
module tb_memory_arbiter;
   import cpu_types_pkg::*;

   localparam int LIM = 8;

   logic        CLK;
   logic        RST;
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] iload;
   logic        iwait;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic [31:0] dload;
   logic        dwait;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   ramstate_t   ramstate;
`ifdef MEMARB_STATS_EN
   logic [31:0] dacc_cnt;
   logic [31:0] iacc_cnt;
`endif

   memory_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iload    (iload),
      .iwait    (iwait),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dload    (dload),
      .dwait    (dwait),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate)
`ifdef MEMARB_STATS_EN
      ,
      .dacc_cnt (dacc_cnt),
      .iacc_cnt (iacc_cnt)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   // Model: who owns the RAM (0 none, 1 dcache, 2 icache),
   // whether the dcache is on its second block word, and how
   // long the icache has been kept waiting.
   int          m_owner = 0;
   bit          m_second = 0;
   int          m_starve = 0;
   bit          m_valid = 0;
   logic [31:0] m_dacc = 0;
   logic [31:0] m_iacc = 0;

   always @(posedge CLK) begin
      if (RST) begin
         m_owner  <= 0;
         m_second <= 0;
         m_starve <= 0;
         m_dacc   <= 0;
         m_iacc   <= 0;
         m_valid  <= 1;
      end else if (m_valid) begin
         if (iREN && m_owner != 2)
            m_starve <= (m_starve < 15) ? m_starve + 1 : 15;
         if (m_owner == 0) begin
            if (iREN && m_starve >= LIM) m_owner <= 2;
            else if (dREN || dWEN) begin
               m_owner  <= 1;
               m_second <= 0;
            end else if (iREN) m_owner <= 2;
         end else if (m_owner == 1) begin
            if (ramstate == ACCESS) m_dacc <= m_dacc + 1;
            if (!(dREN || dWEN)) m_owner <= 0;
            else if (ramstate == ACCESS) begin
               if (!m_second && !daddr[2]) m_second <= 1;
               else m_owner <= 0;
            end
         end else begin
            if (ramstate == ACCESS) begin
               m_iacc   <= m_iacc + 1;
               m_starve <= 0;
               m_owner  <= 0;
            end else if (!iREN) m_owner <= 0;
         end
      end
   end

   always @(negedge CLK) begin
      if (m_valid) begin
         logic acc;
         logic [31:0] e_addr;
         logic [31:0] e_st;
         logic [31:0] e_il;
         logic [31:0] e_dl;
         logic e_ren;
         logic e_wen;
         logic e_iw;
         logic e_dw;
         acc    = (ramstate == ACCESS);
         e_addr = 0;
         e_st   = 0;
         e_il   = 0;
         e_dl   = 0;
         e_ren  = 0;
         e_wen  = 0;
         e_iw   = 1;
         e_dw   = 1;
         if (m_owner == 1) begin
            e_addr = daddr;
            e_st   = dstore;
            e_wen  = dWEN;
            e_ren  = dREN && !dWEN;
            e_dl   = ramload;
            e_dw   = !acc;
         end else if (m_owner == 2) begin
            e_addr = iaddr;
            e_ren  = 1;
            e_il   = ramload;
            e_iw   = !acc;
         end
         chk("m_ramREN", ramREN, e_ren);
         chk("m_ramWEN", ramWEN, e_wen);
         chk("m_ramaddr", ramaddr, e_addr);
         chk("m_ramstore", ramstore, e_st);
         chk("m_iload", iload, e_il);
         chk("m_dload", dload, e_dl);
         chk("m_iwait", iwait, e_iw);
         chk("m_dwait", dwait, e_dw);
`ifdef MEMARB_STATS_EN
         chk("m_dacc", dacc_cnt, m_dacc);
         chk("m_iacc", iacc_cnt, m_iacc);
`endif
      end
   end

   task automatic nxt;
      @(posedge CLK);
      #1;
   endtask

   task automatic mid;
      @(negedge CLK);
   endtask

   initial begin
      int hits;
      int t_hit[2];
      logic dw_s;
      RST      = 1;
      iREN     = 0;
      iaddr    = 0;
      dREN     = 0;
      dWEN     = 0;
      daddr    = 0;
      dstore   = 0;
      ramload  = 0;
      ramstate = FREE;
      nxt;
      nxt;
      mid;
      chk("rst_ramREN", ramREN, 0);
      chk("rst_ramWEN", ramWEN, 0);
      chk("rst_ramaddr", ramaddr, 0);
      chk("rst_iwait", iwait, 1);
      chk("rst_dwait", dwait, 1);
      chk("rst_iload", iload, 0);
`ifdef MEMARB_STATS_EN
      chk("rst_dacc", dacc_cnt, 0);
`endif
      RST = 0;
      nxt;

      // icache read with two BUSY cycles
      iREN     = 1;
      iaddr    = 32'h40;
      ramstate = BUSY;
      ramload  = 32'hDEADBEEF;
      mid;
      chk("i_idle_ren", ramREN, 0);
      nxt;
      mid;
      chk("i_busy_ren", ramREN, 1);
      chk("i_busy_addr", ramaddr, 32'h40);
      chk("i_busy_wait", iwait, 1);
      nxt;
      mid;
      nxt;
      ramstate = ACCESS;
      mid;
      chk("i_acc_wait", iwait, 0);
      chk("i_acc_load", iload, 32'hDEADBEEF);
      chk("i_acc_wen", ramWEN, 0);
      nxt;
      iREN     = 0;
      ramstate = FREE;
      mid;
      chk("i_after_wait", iwait, 1);
      nxt;

      // dcache write block beats icache with starve at 0
      iREN     = 1;
      iaddr    = 32'h80;
      dWEN     = 1;
      daddr    = 32'h100;
      dstore   = 32'h11;
      ramstate = ACCESS;
      mid;
      nxt;
      mid;
      chk("d0_wen", ramWEN, 1);
      chk("d0_addr", ramaddr, 32'h100);
      chk("d0_dwait", dwait, 0);
      chk("d0_iwait", iwait, 1);
      nxt;
      daddr  = 32'h104;
      dstore = 32'h22;
      mid;
      chk("d1_addr", ramaddr, 32'h104);
      chk("d1_store", ramstore, 32'h22);
      chk("d1_dwait", dwait, 0);
      nxt;
      dWEN = 0;
      mid;
      chk("d_idle_iwait", iwait, 1);
      nxt;
      mid;
      chk("i2_addr", ramaddr, 32'h80);
      chk("i2_iwait", iwait, 0);
      nxt;
      iREN = 0;

      // write wins over read
      dREN   = 1;
      dWEN   = 1;
      daddr  = 32'h200;
      dstore = 32'h12345678;
      mid;
      nxt;
      mid;
      chk("rw_wen", ramWEN, 1);
      chk("rw_ren", ramREN, 0);
      chk("rw_store", ramstore, 32'h12345678);
      nxt;
      daddr = 32'h204;
      mid;
      chk("rw1_addr", ramaddr, 32'h204);
      nxt;
      dREN = 0;
      dWEN = 0;
      mid;
      nxt;

      // continuous dcache blocks against a waiting icache
      iREN  = 1;
      iaddr = 32'hC0;
      dWEN  = 1;
      daddr = 32'h100;
      hits  = 0;
      for (int c = 0; c < 40 && hits < 2; c++) begin
         mid;
         dw_s = dwait;
         if (!iwait) begin
            t_hit[hits] = c;
            hits++;
         end
         nxt;
         if (!dw_s)
            daddr = (daddr == 32'h100) ? 32'h104 : 32'h100;
      end
      iREN = 0;
      dWEN = 0;
      chk("starve_hits", hits, 2);
      if (hits == 2) begin
         chk("starve_first", t_hit[0], 10);
         chk("starve_second", t_hit[1], 21);
      end
      mid;
      nxt;

      // ERROR retried until ACCESS
      dREN     = 1;
      daddr    = 32'h304;
      ramload  = 32'hCAFEF00D;
      ramstate = ERROR;
      mid;
      nxt;
      for (int k = 0; k < 5; k++) begin
         mid;
         chk("err_dwait", dwait, 1);
         chk("err_addr", ramaddr, 32'h304);
         nxt;
      end
      ramstate = ACCESS;
      mid;
      chk("err_acc_dwait", dwait, 0);
      chk("err_acc_dload", dload, 32'hCAFEF00D);
      nxt;
      dREN     = 0;
      ramstate = FREE;
      mid;
      nxt;

      // reset between block beats
      dWEN     = 1;
      daddr    = 32'h400;
      dstore   = 32'h55;
      ramstate = ACCESS;
      mid;
      nxt;
      mid;
      nxt;
      daddr = 32'h404;
      RST   = 1;
      mid;
      chk("rst_mid_wen", ramWEN, 1);
      nxt;
      RST   = 0;
      daddr = 32'h400;
      mid;
      chk("rstb_wen", ramWEN, 0);
      chk("rstb_dwait", dwait, 1);
      chk("rstb_iwait", iwait, 1);
      chk("rstb_addr", ramaddr, 0);
`ifdef MEMARB_STATS_EN
      chk("rstb_dacc", dacc_cnt, 0);
      chk("rstb_iacc", iacc_cnt, 0);
`endif
      nxt;
      mid;
      chk("rsta_addr", ramaddr, 32'h400);
      chk("rsta_dwait", dwait, 0);
      nxt;
      mid;
      chk("rsta_lock", ramWEN, 1);
      nxt;
      dWEN = 0;
      mid;
      chk("rsta_idle", ramWEN, 0);
      nxt;
      nxt;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not end, got timeout want finish");
      $fatal(1);
   end

endmodule
